// File: rtl/spi_burst_master.sv
// SPI burst master: one chip-select-framed burst of 1..MAX_BYTES bytes over ready/valid byte ports.
// Build option SPI_BIT_REVERSE_EN bit-reverses both byte ports; wire order stays MSB first.
module spi_burst_master #(
  parameter int CLK_DIV   = 2,
  parameter int MAX_BYTES = 64,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           start_in,
  input  logic [1:0]                     mode_in,
  input  logic [$clog2(MAX_BYTES+1)-1:0] len_in,
  output logic                           busy_out,
  input  logic [7:0]                     tx_data_in,
  input  logic                           tx_valid_in,
  output logic                           tx_ready_out,
  output logic [7:0]                     rx_data_out,
  output logic                           rx_valid_out,
  output logic                           done_out,
  output logic                           n_ss_out,
  output logic                           sclk_out,
  output logic                           mosi_out,
  input  logic                           miso_in
);

  localparam int LW     = $clog2(MAX_BYTES + 1);
  localparam int DW     = $clog2(CLK_DIV + 1);
  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW     = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD} state_t;

  state_t          state, next_state;
  logic [1:0]      mode;
  logic [LW-1:0]   remaining;
  logic [CW-1:0]   ph_cnt;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      half_cnt;
  logic [7:0]      tx_shift;
  logic [7:0]      rx_shift;
  logic [7:0]      tx_word;
  logic [7:0]      rx_word;
  logic [7:0]      rx_next;
  logic [7:0]      rx_final;
  logic            accept;
  logic            handshake;
  logic            half_end;
  logic            shift_end;
  logic            leading;
  logic            sample_now;

  assign accept     = (state == IDLE) && start_in && (len_in != '0);
  assign handshake  = (state == LOAD) && tx_valid_in;
  assign half_end   = (state == SHIFT) && (div_cnt == DW'(CLK_DIV - 1));
  assign shift_end  = half_end && (half_cnt == 4'd15);
  // Even half-periods end on the leading SCLK edge; CPHA picks which edge samples MISO.
  assign leading    = ~half_cnt[0];
  assign sample_now = leading ^ mode[0];
  assign rx_next    = {rx_shift[6:0], miso_in};
  assign rx_final   = sample_now ? rx_next : rx_shift;

`ifdef SPI_BIT_REVERSE_EN
  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  always_comb begin
    tx_word = bit_rev(tx_data_in);
    rx_word = bit_rev(rx_final);
  end
`else
  always_comb begin
    tx_word = tx_data_in;
    rx_word = rx_final;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    busy_out     = 1'b1;
    n_ss_out     = 1'b0;
    tx_ready_out = 1'b0;
    unique case (state)
      IDLE: begin
        busy_out = 1'b0;
        n_ss_out = 1'b1;
        if (accept) next_state = SETUP;
      end
      SETUP: if (ph_cnt == CW'(CS_SETUP - 1)) next_state = LOAD;
      LOAD: begin
        tx_ready_out = 1'b1;
        if (tx_valid_in) next_state = SHIFT;
      end
      SHIFT: if (shift_end) next_state = (remaining == LW'(1)) ? HOLD : LOAD;
      HOLD:  if (ph_cnt == CW'(CS_HOLD - 1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mode         <= '0;
      remaining    <= '0;
      ph_cnt       <= '0;
      div_cnt      <= '0;
      half_cnt     <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      sclk_out     <= 1'b0;
      mosi_out     <= 1'b0;
      rx_data_out  <= '0;
      rx_valid_out <= 1'b0;
      done_out     <= 1'b0;
    end else begin
      rx_valid_out <= 1'b0;
      done_out     <= 1'b0;

      if ((state == SETUP || state == HOLD) && state == next_state) ph_cnt <= ph_cnt + 1'b1;
      else                                                          ph_cnt <= '0;

      if (accept) begin
        mode      <= mode_in;
        remaining <= len_in;
        sclk_out  <= mode_in[1];
      end

      if (handshake) begin
        div_cnt  <= '0;
        half_cnt <= '0;
        if (mode[0]) begin
          tx_shift <= tx_word;
        end else begin
          mosi_out <= tx_word[7];
          tx_shift <= {tx_word[6:0], 1'b0};
        end
      end

      if (state == SHIFT) begin
        if (half_end) begin
          div_cnt  <= '0;
          half_cnt <= half_cnt + 4'd1;
          sclk_out <= shift_end ? mode[1] : ~sclk_out;
          if (sample_now) begin
            rx_shift <= rx_next;
          end else begin
            mosi_out <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
          if (shift_end) begin
            rx_data_out  <= rx_word;
            rx_valid_out <= 1'b1;
            remaining    <= remaining - 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      if (state == HOLD && next_state == IDLE) done_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_burst_master.sv
// Bench for spi_burst_master: table vectors, hand sequences and random bursts checked
// against a wire-level SPI slave model and burst-length arithmetic.
`timescale 1ns/1ps
module tb_spi_burst_master;

  localparam int CLK_DIV   = 2;
  localparam int MAX_BYTES = 64;
  localparam int CS_SETUP  = 2;
  localparam int CS_HOLD   = 2;
  localparam int LW        = $clog2(MAX_BYTES + 1);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic [1:0]    mode_in = '0;
  logic [LW-1:0] len_in = '0;
  logic          busy_out;
  logic [7:0]    tx_data_in = '0;
  logic          tx_valid_in = 1'b0;
  logic          tx_ready_out;
  logic [7:0]    rx_data_out;
  logic          rx_valid_out;
  logic          done_out;
  logic          n_ss_out;
  logic          sclk_out;
  logic          mosi_out;
  logic          miso_w;

  logic          miso_drv = 1'b0;
  logic          loopback = 1'b0;
  logic          armed = 1'b0;
  logic [1:0]    s_mode = '0;
  bit            s_bits [$];
  bit            mosi_got [$];
  logic [7:0]    rx_got [$];
  logic [7:0]    tx_buf [8];
  logic [7:0]    sl_buf [8];

  int errors = 0;
  int checks = 0;

  assign miso_w = loopback ? mosi_out : miso_drv;

  spi_burst_master #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BYTES(MAX_BYTES),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .mode_in     (mode_in),
    .len_in      (len_in),
    .busy_out    (busy_out),
    .tx_data_in  (tx_data_in),
    .tx_valid_in (tx_valid_in),
    .tx_ready_out(tx_ready_out),
    .rx_data_out (rx_data_out),
    .rx_valid_out(rx_valid_out),
    .done_out    (done_out),
    .n_ss_out    (n_ss_out),
    .sclk_out    (sclk_out),
    .mosi_out    (mosi_out),
    .miso_in     (miso_w)
  );

  always #5 clk_in = ~clk_in;

  // Slave: samples MOSI on its sampling edge, shifts the next MISO bit out on the other edge.
  always @(sclk_out) begin
    if (armed) begin
      if ((sclk_out != s_mode[1]) ^ s_mode[0]) mosi_got.push_back(mosi_out);
      else if (s_bits.size() != 0)             miso_drv = s_bits.pop_front();
      else                                     miso_drv = 1'b0;
    end
  end

  function automatic logic [7:0] port_map(input logic [7:0] b);
`ifdef SPI_BIT_REVERSE_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
`else
    return b;
`endif
  endfunction

  function automatic int burst_cycles(input int n, input int stall);
    return 1 + CS_SETUP + n * (1 + 16 * CLK_DIV) + CS_HOLD + stall;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_burst(input logic [1:0] m, input int n, input int stall_at,
                           input int stall_len, output int done_k);
    int k, idx, held;
    bit ss_ok, idle_ok;
    s_bits.delete();
    mosi_got.delete();
    rx_got.delete();
    for (int b = 0; b < n; b++)
      for (int i = 7; i >= 0; i--) s_bits.push_back(sl_buf[b][i]);
    s_mode = m;
    armed  = 1'b0;
    if (!m[0] && s_bits.size() != 0) miso_drv = s_bits.pop_front();
    @(negedge clk_in);
    start_in = 1'b1;
    mode_in  = m;
    len_in   = LW'(n);
    k = 0; idx = 0; held = 0; done_k = -1; ss_ok = 1'b1; idle_ok = 1'b1;
    while (done_k < 0 && k < 5000) begin
      @(negedge clk_in);
      k++;
      if (rx_valid_out) rx_got.push_back(rx_data_out);
      if (done_out) begin
        done_k = k;
        check("done_frame", {busy_out, n_ss_out, sclk_out}, {1'b0, 1'b1, m[1]});
      end else begin
        if (n_ss_out !== 1'b0 || busy_out !== 1'b1) ss_ok = 1'b0;
        if ((k == 1 || tx_ready_out) && sclk_out !== m[1]) idle_ok = 1'b0;
      end
      if (done_k >= 0) begin
        start_in    = 1'b0;
        tx_valid_in = 1'b0;
      end else begin
        start_in    = 1'($urandom);
        mode_in     = 2'($urandom);
        len_in      = LW'($urandom_range(0, MAX_BYTES));
        tx_valid_in = 1'b0;
        tx_data_in  = 8'($urandom);
        if (tx_ready_out) begin
          armed = 1'b1;
          if (idx == stall_at && held < stall_len) begin
            held++;
          end else if (idx < n) begin
            tx_valid_in = 1'b1;
            tx_data_in  = tx_buf[idx];
            idx++;
          end
        end
      end
    end
    armed   = 1'b0;
    mode_in = '0;
    len_in  = '0;
    check("done_seen", done_k >= 0, 1'b1);
    check("ss_framed", ss_ok, 1'b1);
    check("sclk_idle_level", idle_ok, 1'b1);
    @(negedge clk_in);
    check("done_single_pulse", {done_out, busy_out}, 2'b00);
  endtask

  task automatic check_burst(input string nm, input int n, input bit lb,
                             input int exp_done, input int done_k);
    logic [7:0] wb, got_rx, exp_rx;
    check({nm, "_done_cycle"}, done_k, exp_done);
    check({nm, "_rx_count"}, rx_got.size(), n);
    check({nm, "_mosi_bits"}, mosi_got.size(), 8 * n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 8; i++)
        wb[7-i] = (8 * b + i < mosi_got.size()) ? mosi_got[8*b+i] : 1'bx;
      check({nm, "_mosi_byte"}, wb, port_map(tx_buf[b]));
      exp_rx = lb ? tx_buf[b] : port_map(sl_buf[b]);
      got_rx = (b < rx_got.size()) ? rx_got[b] : 8'hxx;
      check({nm, "_rx_byte"}, got_rx, exp_rx);
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int         len;
    logic [7:0] tx [4];
    logic [7:0] sl [4];
    int         stall_at;
    int         stall_len;
    int         exp_done;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dk, n, sa, sl;
    logic [1:0] m;
    logic fb, quiet;

    vecs[0] = '{mode: 2'd0, len: 3, tx: '{8'h8A, 8'h14, 8'hFF, 8'h00},
                sl: '{8'h00, 8'h00, 8'h00, 8'h00}, stall_at: 99, stall_len: 0, exp_done: 104};
    vecs[1] = '{mode: 2'd0, len: 3, tx: '{8'h90, 8'h00, 8'h00, 8'h00},
                sl: '{8'h00, 8'hFF, 8'h55, 8'h00}, stall_at: 99, stall_len: 0, exp_done: 104};
    vecs[2] = '{mode: 2'd1, len: 2, tx: '{8'h3C, 8'hC3, 8'h00, 8'h00},
                sl: '{8'hA5, 8'h5A, 8'h00, 8'h00}, stall_at: 99, stall_len: 0, exp_done: 71};
    vecs[3] = '{mode: 2'd2, len: 1, tx: '{8'h81, 8'h00, 8'h00, 8'h00},
                sl: '{8'h7E, 8'h00, 8'h00, 8'h00}, stall_at: 99, stall_len: 0, exp_done: 38};
    vecs[4] = '{mode: 2'd0, len: 3, tx: '{8'h11, 8'h22, 8'h33, 8'h00},
                sl: '{8'h44, 8'h55, 8'h66, 8'h00}, stall_at: 1, stall_len: 10, exp_done: 114};

    // Reset defaults
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_outputs",
          {n_ss_out, sclk_out, mosi_out, busy_out, tx_ready_out, rx_valid_out, rx_data_out, done_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
    rst_in = 1'b0;

    // Zero-length start is ignored
    start_in = 1'b1; len_in = '0; mode_in = 2'd3;
    @(negedge clk_in);
    start_in = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      if (busy_out !== 1'b0 || done_out !== 1'b0 || n_ss_out !== 1'b1 || sclk_out !== 1'b0) quiet = 1'b0;
      @(negedge clk_in);
    end
    check("zero_len_ignored", quiet, 1'b1);

    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < 4; b++) begin
        tx_buf[b] = vecs[v].tx[b];
        sl_buf[b] = vecs[v].sl[b];
      end
      run_burst(vecs[v].mode, vecs[v].len, vecs[v].stall_at, vecs[v].stall_len, dk);
      check_burst($sformatf("vec%0d", v), vecs[v].len, 1'b0, vecs[v].exp_done, dk);
    end

    // Mode 3 loopback
    tx_buf[0] = 8'hA5;
    sl_buf[0] = 8'h00;
    loopback = 1'b1;
    run_burst(2'd3, 1, 99, 0, dk);
    loopback = 1'b0;
    check_burst("mode3_loop", 1, 1'b1, 38, dk);
    repeat (3) @(negedge clk_in);
    check("mode3_idle_after", {sclk_out, n_ss_out}, 2'b11);

    // Reset in the middle of SHIFT
    @(negedge clk_in);
    start_in = 1'b1; mode_in = 2'd0; len_in = LW'(2);
    @(negedge clk_in);
    start_in = 1'b0;
    for (int w = 0; w < 20 && !tx_ready_out; w++) @(negedge clk_in);
    check("rst_seq_load", tx_ready_out, 1'b1);
    tx_valid_in = 1'b1; tx_data_in = 8'h5A;
    @(negedge clk_in);
    tx_valid_in = 1'b0;
    repeat (9) @(negedge clk_in);
    check("rst_seq_busy", {busy_out, n_ss_out}, 2'b10);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_mid_shift", {n_ss_out, busy_out, done_out, tx_ready_out, sclk_out}, 5'b10000);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk_in);
      if (done_out !== 1'b0 || rx_valid_out !== 1'b0 || busy_out !== 1'b0) quiet = 1'b0;
    end
    check("rst_quiet", quiet, 1'b1);

    tx_buf[0] = 8'h01;
    sl_buf[0] = 8'hC3;
    run_burst(2'd0, 1, 99, 0, dk);
    check_burst("post_rst", 1, 1'b0, 38, dk);
    fb = (mosi_got.size() > 0) ? mosi_got[0] : 1'bx;
`ifdef SPI_BIT_REVERSE_EN
    check("first_wire_bit", fb, 1'b1);
`else
    check("first_wire_bit", fb, 1'b0);
`endif

    // Random bursts
    for (int r = 0; r < 8; r++) begin
      m  = 2'($urandom);
      n  = $urandom_range(1, 4);
      sa = $urandom_range(0, 4);
      sl = $urandom_range(0, 5);
      for (int b = 0; b < n; b++) begin
        tx_buf[b] = 8'($urandom);
        sl_buf[b] = 8'($urandom);
      end
      run_burst(m, n, sa, sl, dk);
      check_burst($sformatf("rand%0d_m%0d", r, m), n, 1'b0, burst_cycles(n, (sa < n) ? sl : 0), dk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
